// File: rtl/face_pkg.sv
// Shared face-selection types: face index encoding, reader control states, colour key.
// Pure declarations; no latency or backpressure.
package face_pkg;

    localparam int FACE_NUM_IMAGES = 8;
    localparam int FACE_IDX_W      = $clog2(FACE_NUM_IMAGES);

    typedef logic [FACE_IDX_W-1:0] face_idx_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        REQ,
        SETTLE,
        LATCH
    } ctrl_state_t;

    localparam logic [15:0] TRANSPARENT_KEY = 16'hF81F;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with async clear; latency DEPTH cycles.
// Always accepts a new word each cycle; no backpressure.
module pipe_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/face_sprite_reader.sv
// Per-frame face latch plus sprite-ROM address generation and keyed pixel output.
// Pixel latency 1 + ROM_LATENCY cycles; fully pipelined, never stalls.
module face_sprite_reader
    import face_pkg::*;
#(
    parameter int               NUM_IMAGES  = 8,
    parameter int               SPRITE_W    = 64,
    parameter int               SPRITE_H    = 64,
    parameter int               ROM_LATENCY = 2,
    parameter int               PIX_W       = 16,
    parameter logic [PIX_W-1:0] TRANSPARENT = PIX_W'(TRANSPARENT_KEY)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          frame_start,
    input  logic [$clog2(NUM_IMAGES)-1:0]                 face_state,
    input  logic [10:0]                                   hcount,
    input  logic [9:0]                                    vcount,
    input  logic [10:0]                                   x_pos,
    input  logic [9:0]                                    y_pos,
    output logic                                          update_face,
    output logic [$clog2(NUM_IMAGES*SPRITE_W*SPRITE_H)-1:0] rom_addr,
    input  logic [PIX_W-1:0]                              rom_data,
    output logic [$clog2(NUM_IMAGES)-1:0]                 active_face,
    output logic [PIX_W-1:0]                              pixel_out,
    output logic                                          pixel_valid
);

    localparam int WB = $clog2(SPRITE_W);
    localparam int HB = $clog2(SPRITE_H);

    ctrl_state_t state;
    logic        settle_cnt;

    // update_face is set on the transition into REQ so it is high for exactly that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_FRAME;
            update_face <= 1'b0;
            settle_cnt  <= 1'b0;
            active_face <= '0;
        end else begin
            update_face <= 1'b0;
            case (state)
                WAIT_FRAME: begin
                    if (frame_start) begin
                        state       <= REQ;
                        update_face <= 1'b1;
                    end
                end
                REQ: begin
                    state      <= SETTLE;
                    settle_cnt <= 1'b0;
                end
                SETTLE: begin
                    settle_cnt <= 1'b1;
                    if (settle_cnt) state <= LATCH;
                end
                LATCH: begin
                    active_face <= face_state;
                    state       <= WAIT_FRAME;
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end

    // Window bounds are one bit wider so a sprite hanging off the raster clips instead of wrapping.
    logic [11:0]   x_end;
    logic [10:0]   y_end;
    logic          in_win;
    logic [WB-1:0] dx;
    logic [HB-1:0] dy;

    assign x_end  = {1'b0, x_pos} + 12'(SPRITE_W);
    assign y_end  = {1'b0, y_pos} + 11'(SPRITE_H);
    assign in_win = (hcount >= x_pos) && ({1'b0, hcount} < x_end) &&
                    (vcount >= y_pos) && ({1'b0, vcount} < y_end);
    assign dx     = hcount[WB-1:0] - x_pos[WB-1:0];
    assign dy     = vcount[HB-1:0] - y_pos[HB-1:0];

    logic win_q;
    logic win_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            win_q    <= 1'b0;
        end else begin
            win_q <= in_win;
            if (in_win) rom_addr <= {active_face, dy, dx};
        end
    end

    pipe_delay #(
        .DEPTH (ROM_LATENCY),
        .WIDTH (1)
    ) u_win_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (win_q),
        .dout (win_d)
    );

    assign pixel_valid = win_d && (rom_data != TRANSPARENT);
    assign pixel_out   = pixel_valid ? rom_data : '0;

endmodule

// File: tb/tb_face_sprite_reader.sv
// Scoreboard bench: driver queues expected address/pixel per cycle, monitor compares on negedge.
module tb_face_sprite_reader;

    localparam logic [15:0] TR = 16'hF81F;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [2:0]  face_state;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [10:0] x_pos;
    logic [9:0]  y_pos;
    logic        update_face;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic [2:0]  active_face;
    logic [15:0] pixel_out;
    logic        pixel_valid;

    always #5 clk = ~clk;

    face_sprite_reader dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .face_state  (face_state),
        .hcount      (hcount),
        .vcount      (vcount),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .update_face (update_face),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .active_face (active_face),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid)
    );

    function automatic logic [15:0] rom_word(input int a);
        if (a == 12290) return TR;
        return 16'((a * 37 + 5) & 16'hFFFF);
    endfunction

    // Two-cycle sprite ROM.
    logic [15:0] rd1 = '0;
    logic [15:0] rd2 = '0;
    always @(posedge clk) begin
        rd1 <= rom_word(int'(rom_addr));
        rd2 <= rd1;
    end
    assign rom_data = rd2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int cyc;
        int addr;
        bit iw;
    } exp_t;

    exp_t aq[$];
    exp_t pq[$];
    int   model_face = 0;
    int   last_addr  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clip(input int val, input int hi);
        if (val < 0) return 0;
        if (val > hi) return hi;
        return val;
    endfunction

    task automatic drive_px(input int h, input int v, input int x, input int y);
        bit iw;
        int a;
        hcount = 11'(h);
        vcount = 10'(v);
        x_pos  = 11'(x);
        y_pos  = 10'(y);
        iw = (h >= x) && (h < x + 64) && (v >= y) && (v < y + 64);
        a  = model_face * 4096 + (v - y) * 64 + (h - x);
        if (iw) last_addr = a;
        aq.push_back('{cyc + 1, last_addr, 1'b0});
        pq.push_back('{cyc + 3, a, iw});
        step();
    endtask

    task automatic frame_seq(input int face, input bit second, input bit rst_mid, input int prev);
        face_state = 3'(face);
        for (int i = 0; i < 10; i++) begin
            frame_start = (i == 0) || (second && i == 2);
            if (rst_mid) rst = (i == 2);
            #2;
            chk("update_face", update_face, 32'(i == 1));
            if (rst_mid) chk("active_face", active_face, (i >= 2) ? 0 : prev);
            else         chk("active_face", active_face, (i >= 5) ? face : prev);
            step();
        end
        frame_start = 1'b0;
        rst         = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] w;
        bit          ev;
        if (!rst) begin
            while (aq.size() > 0 && aq[0].cyc <= cyc) begin
                e = aq.pop_front();
                chk("rom_addr", 32'(rom_addr), e.addr);
            end
            while (pq.size() > 0 && pq[0].cyc <= cyc) begin
                e  = pq.pop_front();
                w  = rom_word(e.addr);
                ev = e.iw && (w != TR);
                chk("pixel_valid", 32'(pixel_valid), 32'(ev));
                chk("pixel_out", 32'(pixel_out), ev ? 32'(w) : 0);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        frame_start = 1'b1;
        face_state  = 3'd5;
        hcount      = 11'd2047;
        vcount      = 10'd1023;
        x_pos       = 11'd0;
        y_pos       = 10'd0;
        repeat (3) step();
        chk("rst update_face", update_face, 0);
        chk("rst active_face", active_face, 0);
        chk("rst rom_addr", 32'(rom_addr), 0);
        chk("rst pixel_valid", pixel_valid, 0);
        chk("rst pixel_out", pixel_out, 0);
        rst         = 1'b0;
        frame_start = 1'b0;
        repeat (3) begin
            step();
            chk("post-rst update_face", update_face, 0);
        end

        frame_seq(5, 1'b0, 1'b0, 0);
        frame_seq(2, 1'b1, 1'b0, 5);
        frame_seq(6, 1'b0, 1'b1, 2);
        repeat (3) begin
            chk("no latch after rst", active_face, 0);
            step();
        end
        frame_seq(3, 1'b0, 1'b0, 0);
        model_face = 3;

        drive_px(100, 50, 100, 50);
        drive_px(163, 113, 100, 50);
        drive_px(164, 50, 100, 50);
        for (int h = 100; h < 107; h++) drive_px(h, 50, 100, 50);
        drive_px(99, 50, 100, 50);
        drive_px(100, 49, 100, 50);

        for (int b = 0; b < 12; b++) begin
            int x = $urandom_range(0, 2047);
            int y = $urandom_range(0, 1023);
            for (int k = 0; k < 25; k++) begin
                int rh = $urandom_range(0, 80);
                int rv = $urandom_range(0, 72);
                if (k == 12) x = clip(x + int'($urandom_range(0, 2)) - 1, 2047);
                drive_px(clip(x - 8 + rh, 2047), clip(y - 4 + rv, 1023), x, y);
            end
        end

        for (int k = 0; k < 60; k++) begin
            int h = (k % 2 == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(1990, 2047));
            drive_px(h, 50 + int'($urandom_range(0, 63)), 2000, 50);
        end
        for (int k = 0; k < 40; k++) begin
            int v = (k % 2 == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(990, 1023));
            drive_px(300 + int'($urandom_range(0, 63)), v, 300, 1000);
        end

        repeat (5) drive_px(2047, 1023, 0, 0);
        repeat (4) step();
        chk("scoreboard drained", aq.size() + pq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
